// File: rtl/arp_cache_table_if.sv
// Learn, flush and lookup signals between the ARP cache table and its clients.
// master = client side (RX parser / TX path), slave = the cache table.
interface arp_cache_table_if #(
    parameter int ENTRIES = 8
);
    localparam int CW = $clog2(ENTRIES + 1);

    logic          arp_found;
    logic [31:0]   arp_rec_source_ip_addr;
    logic [47:0]   arp_rec_source_mac_addr;
    logic          flush;
    logic          lookup_req;
    logic [31:0]   destination_ip_addr;
    logic          lookup_busy;
    logic          lookup_done;
    logic [47:0]   destination_mac_addr;
    logic          mac_not_exist;
    logic [CW-1:0] entry_count;

    modport master (
        output arp_found, arp_rec_source_ip_addr, arp_rec_source_mac_addr,
        output flush, lookup_req, destination_ip_addr,
        input  lookup_busy, lookup_done, destination_mac_addr, mac_not_exist, entry_count
    );

    modport slave (
        input  arp_found, arp_rec_source_ip_addr, arp_rec_source_mac_addr,
        input  flush, lookup_req, destination_ip_addr,
        output lookup_busy, lookup_done, destination_mac_addr, mac_not_exist, entry_count
    );
endinterface

// File: rtl/arp_cache_table.sv
// Multi-entry IP->MAC cache: one-cycle learn, aging, round-robin replacement, sequential lookup.
// Lookup: hit at entry k done at k+2, miss at ENTRIES+1, broadcast at 1; no backpressure, busy flags a scan.
module arp_cache_table #(
    parameter int ENTRIES  = 8,
    parameter int TICK_DIV = 125000000,
    parameter int AGE_MAX  = 300
) (
    input  logic clk,
    input  logic rst_n,
    arp_cache_table_if.slave bus
);
    localparam int IW = $clog2(ENTRIES);
    localparam int CW = $clog2(ENTRIES + 1);
    localparam int AW = $clog2(AGE_MAX + 1);
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    logic [ENTRIES-1:0] valid_q;
    logic [31:0]        ip_q   [ENTRIES];
    logic [47:0]        mac_q  [ENTRIES];
    logic [AW-1:0]      age_q  [ENTRIES];
    logic [IW-1:0]      rr_q;
    logic [TW-1:0]      tick_cnt;
    logic               tick;

    state_t             state_q;
    logic [IW-1:0]      idx_q;
    logic [31:0]        ip_lat_q;

    logic               learn_ok;
    logic               hit_any, free_any;
    logic [IW-1:0]      hit_idx, free_idx, wr_idx;
    logic               cmp_hit, bypass;
    logic               scan_end, scan_hit;
    logic [47:0]        scan_mac;
    logic [CW-1:0]      cnt;

    assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
    assign learn_ok = bus.arp_found && !bus.flush &&
                      (bus.arp_rec_source_ip_addr != 32'h0) &&
                      (bus.arp_rec_source_ip_addr != 32'hFFFF_FFFF);

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (ip_q[i] == bus.arp_rec_source_ip_addr)) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
        wr_idx = hit_any ? hit_idx : (free_any ? free_idx : rr_q);
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            cnt = cnt + CW'(valid_q[i]);
        end
    end

    assign bus.entry_count = cnt;

    // Learn is applied after aging so a same-cycle learn revives the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            rr_q     <= '0;
            tick_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ip_q[i]  <= '0;
                mac_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (bus.flush) begin
                valid_q <= '0;
                rr_q    <= '0;
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (tick && valid_q[i]) begin
                        if (age_q[i] == AW'(AGE_MAX - 1)) begin
                            valid_q[i] <= 1'b0;
                            age_q[i]   <= '0;
                        end else begin
                            age_q[i] <= age_q[i] + 1'b1;
                        end
                    end
                end
                if (learn_ok) begin
                    valid_q[wr_idx] <= 1'b1;
                    age_q[wr_idx]   <= '0;
                    ip_q[wr_idx]    <= bus.arp_rec_source_ip_addr;
                    mac_q[wr_idx]   <= bus.arp_rec_source_mac_addr;
                    if (!hit_any && !free_any) begin
                        rr_q <= rr_q + 1'b1;
                    end
                end
            end
        end
    end

    assign cmp_hit = valid_q[idx_q] && (ip_q[idx_q] == ip_lat_q);
    assign bypass  = learn_ok && (bus.arp_rec_source_ip_addr == ip_lat_q);

    always_comb begin
        scan_end = 1'b0;
        scan_hit = 1'b0;
        scan_mac = mac_q[idx_q];
        if (bus.flush) begin
            scan_end = 1'b1;
        end else if (bypass) begin
            scan_end = 1'b1;
            scan_hit = 1'b1;
            scan_mac = bus.arp_rec_source_mac_addr;
        end else if (cmp_hit) begin
            scan_end = 1'b1;
            scan_hit = 1'b1;
        end else if (idx_q == IW'(ENTRIES - 1)) begin
            scan_end = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                  <= IDLE;
            idx_q                    <= '0;
            ip_lat_q                 <= '0;
            bus.lookup_busy          <= 1'b0;
            bus.lookup_done          <= 1'b0;
            bus.destination_mac_addr <= '0;
            bus.mac_not_exist        <= 1'b0;
        end else begin
            bus.lookup_done <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.lookup_req) begin
                        ip_lat_q <= bus.destination_ip_addr;
                        idx_q    <= '0;
                        if (bus.destination_ip_addr == 32'hFFFF_FFFF) begin
                            state_q                  <= DONE;
                            bus.lookup_done          <= 1'b1;
                            bus.lookup_busy          <= 1'b0;
                            bus.destination_mac_addr <= 48'hFFFF_FFFF_FFFF;
                            bus.mac_not_exist        <= 1'b0;
                        end else begin
                            state_q         <= SEARCH;
                            bus.lookup_busy <= 1'b1;
                        end
                    end else begin
                        state_q         <= IDLE;
                        bus.lookup_busy <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (scan_end) begin
                        state_q           <= DONE;
                        bus.lookup_done   <= 1'b1;
                        bus.lookup_busy   <= 1'b0;
                        bus.mac_not_exist <= !scan_hit;
                        if (scan_hit) begin
                            bus.destination_mac_addr <= scan_mac;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    bus.lookup_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_arp_cache_table.sv
// Directed bench for arp_cache_table: main instance (8 entries, slow aging) and a fast-aging instance.
module tb_arp_cache_table;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic age_rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    arp_cache_table_if #(.ENTRIES(8)) bus ();
    arp_cache_table_if #(.ENTRIES(4)) abus ();

    arp_cache_table #(.ENTRIES(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    arp_cache_table #(.ENTRIES(4), .TICK_DIV(4), .AGE_MAX(3)) u_age (
        .clk   (clk),
        .rst_n (age_rst_n),
        .bus   (abus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
        bus.arp_found               = 1'b1;
        bus.arp_rec_source_ip_addr  = ip;
        bus.arp_rec_source_mac_addr = mac;
        step();
        bus.arp_found = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    // Returns the cycle (relative to the request cycle) where lookup_done is seen, -1 on timeout.
    task automatic do_lookup(input logic [31:0] ip, output int lat);
        bus.lookup_req          = 1'b1;
        bus.destination_ip_addr = ip;
        step();
        bus.lookup_req = 1'b0;
        lat = 1;
        while (!bus.lookup_done && lat < 20) begin
            step();
            lat++;
        end
        if (!bus.lookup_done) lat = -1;
    endtask

    initial begin
        int lat;
        int n;
        logic seen_done;

        bus.arp_found = 1'b0;  bus.arp_rec_source_ip_addr = '0;  bus.arp_rec_source_mac_addr = '0;
        bus.flush = 1'b0;      bus.lookup_req = 1'b0;            bus.destination_ip_addr = '0;
        abus.arp_found = 1'b0; abus.arp_rec_source_ip_addr = '0; abus.arp_rec_source_mac_addr = '0;
        abus.flush = 1'b0;     abus.lookup_req = 1'b0;           abus.destination_ip_addr = '0;

        step();
        step();
        rst_n     = 1'b1;
        age_rst_n = 1'b1;
        n = 0;

        chk("rst_busy",  64'(bus.lookup_busy), 64'd0);
        chk("rst_done",  64'(bus.lookup_done), 64'd0);
        chk("rst_mac",   64'(bus.destination_mac_addr), 64'd0);
        chk("rst_miss",  64'(bus.mac_not_exist), 64'd0);
        chk("rst_count", 64'(bus.entry_count), 64'd0);

        // Aging instance: ticks land on posedges 4, 8, 12, ... after release.
        abus.arp_found = 1'b1;
        abus.arp_rec_source_ip_addr  = 32'h0A01_0101;
        abus.arp_rec_source_mac_addr = 48'h0200_0000_0101;
        step(); n++;
        abus.arp_found = 1'b0;
        chk("age_learn_count", 64'(abus.entry_count), 64'd1);
        while (n < 11) begin step(); n++; end
        chk("age_before_expire", 64'(abus.entry_count), 64'd1);
        step(); n++;
        chk("age_expired", 64'(abus.entry_count), 64'd0);
        abus.arp_found = 1'b1;
        step(); n++;
        abus.arp_found = 1'b0;
        chk("age_relearn_count", 64'(abus.entry_count), 64'd1);
        while (n < 23) begin step(); n++; end
        abus.arp_found = 1'b1;
        abus.arp_rec_source_mac_addr = 48'h0200_0000_0202;
        step(); n++;
        abus.arp_found = 1'b0;
        chk("age_learn_on_tick", 64'(abus.entry_count), 64'd1);
        while (n < 35) begin step(); n++; end
        chk("age_refreshed_alive", 64'(abus.entry_count), 64'd1);
        step(); n++;
        chk("age_refreshed_expire", 64'(abus.entry_count), 64'd0);
        chk("age_lookup_idle", {abus.lookup_busy, abus.lookup_done, abus.mac_not_exist,
                                abus.destination_mac_addr}, 64'd0);

        // Basic learn then hit at entry 0.
        learn(32'hC0A8_010A, 48'h000A_3501_0203);
        do_lookup(32'hC0A8_010A, lat);
        chk("hit0_latency", 64'(lat), 64'd2);
        chk("hit0_mac",     64'(bus.destination_mac_addr), 64'h000A_3501_0203);
        chk("hit0_miss",    64'(bus.mac_not_exist), 64'd0);
        chk("hit0_count",   64'(bus.entry_count), 64'd1);

        // Fill past capacity: 10.0.0.9 replaces entry 0 via round-robin.
        do_flush();
        chk("flush_count", 64'(bus.entry_count), 64'd0);
        for (int i = 1; i <= 9; i++) begin
            learn(32'h0A00_0000 + 32'(i), 48'h0200_0000_0000 + 48'(i));
        end
        chk("full_count", 64'(bus.entry_count), 64'd8);
        do_lookup(32'h0A00_0001, lat);
        chk("evicted_latency", 64'(lat), 64'd9);
        chk("evicted_miss",    64'(bus.mac_not_exist), 64'd1);
        chk("evicted_mac_held", 64'(bus.destination_mac_addr), 64'h000A_3501_0203);
        do_lookup(32'h0A00_0009, lat);
        chk("rr_latency", 64'(lat), 64'd2);
        chk("rr_mac",     64'(bus.destination_mac_addr), 64'h0200_0000_0009);
        do_lookup(32'h0A00_0002, lat);
        chk("e1_latency", 64'(lat), 64'd3);
        chk("e1_mac",     64'(bus.destination_mac_addr), 64'h0200_0000_0002);
        chk("e1_miss",    64'(bus.mac_not_exist), 64'd0);

        // Miss on empty table, then MAC update of an existing IP.
        do_flush();
        do_lookup(32'h0A00_0005, lat);
        chk("empty_latency",  64'(lat), 64'd9);
        chk("empty_miss",     64'(bus.mac_not_exist), 64'd1);
        chk("empty_mac_held", 64'(bus.destination_mac_addr), 64'h0200_0000_0002);
        learn(32'h0A00_0005, 48'hAAAA_AAAA_AAAA);
        learn(32'h0A00_0005, 48'h1122_3344_5566);
        chk("update_count", 64'(bus.entry_count), 64'd1);
        do_lookup(32'h0A00_0005, lat);
        chk("update_latency", 64'(lat), 64'd2);
        chk("update_mac",     64'(bus.destination_mac_addr), 64'h1122_3344_5566);

        // Learn bypass during a scan: arp_found in cycle 3, done in cycle 4.
        bus.lookup_req = 1'b1;
        bus.destination_ip_addr = 32'h0A00_0007;
        step();
        bus.lookup_req = 1'b0;
        step();
        step();
        chk("bypass_busy", 64'(bus.lookup_busy), 64'd1);
        chk("bypass_not_done", 64'(bus.lookup_done), 64'd0);
        bus.arp_found = 1'b1;
        bus.arp_rec_source_ip_addr  = 32'h0A00_0007;
        bus.arp_rec_source_mac_addr = 48'h0A0B_0C0D_0E0F;
        step();
        bus.arp_found = 1'b0;
        chk("bypass_done",  64'(bus.lookup_done), 64'd1);
        chk("bypass_mac",   64'(bus.destination_mac_addr), 64'h0A0B_0C0D_0E0F);
        chk("bypass_miss",  64'(bus.mac_not_exist), 64'd0);
        chk("bypass_count", 64'(bus.entry_count), 64'd2);

        // Flush aborts a scan: done one cycle later as a miss.
        bus.lookup_req = 1'b1;
        bus.destination_ip_addr = 32'h0A00_0063;
        step();
        bus.lookup_req = 1'b0;
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("abort_done",     64'(bus.lookup_done), 64'd1);
        chk("abort_miss",     64'(bus.mac_not_exist), 64'd1);
        chk("abort_busy",     64'(bus.lookup_busy), 64'd0);
        chk("abort_count",    64'(bus.entry_count), 64'd0);
        chk("abort_mac_held", 64'(bus.destination_mac_addr), 64'h0A0B_0C0D_0E0F);

        // Broadcast resolves immediately; reserved IPs are never learned.
        do_lookup(32'hFFFF_FFFF, lat);
        chk("bcast_latency", 64'(lat), 64'd1);
        chk("bcast_mac",     64'(bus.destination_mac_addr), 64'hFFFF_FFFF_FFFF);
        chk("bcast_miss",    64'(bus.mac_not_exist), 64'd0);
        learn(32'h0A00_0001, 48'h0200_0000_0001);
        learn(32'h0000_0000, 48'h0300_0000_0000);
        chk("zero_ip_count", 64'(bus.entry_count), 64'd1);
        learn(32'hFFFF_FFFF, 48'h0300_0000_0001);
        chk("bcast_ip_count", 64'(bus.entry_count), 64'd1);
        do_lookup(32'h0000_0000, lat);
        chk("zero_ip_latency", 64'(lat), 64'd9);
        chk("zero_ip_miss",    64'(bus.mac_not_exist), 64'd1);

        // Reset mid-scan: outputs return to reset values and no done follows.
        bus.lookup_req = 1'b1;
        bus.destination_ip_addr = 32'h0A00_0032;
        step();
        bus.lookup_req = 1'b0;
        step();
        chk("midscan_busy", 64'(bus.lookup_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {bus.lookup_busy, bus.lookup_done, bus.mac_not_exist,
                               bus.destination_mac_addr}, 64'd0);
        chk("midrst_count", 64'(bus.entry_count), 64'd0);
        #1;
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.lookup_done) seen_done = 1'b1;
        end
        chk("midrst_no_done", 64'(seen_done), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
